// File: rtl/tensor_stream_packer_if.sv
// Stream-in / tensor-out bundle for tensor_stream_packer.
// The slave modport is the packer's view; master is the producer/consumer side.
interface tensor_stream_packer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_SIZE    = 16
);
  logic                          s_valid;
  logic                          s_ready;
  logic [DATA_WIDTH-1:0]         s_data;
  logic                          s_last;
  logic [IN_SIZE*DATA_WIDTH-1:0] input_tensor;
  logic                          tensor_valid;
  logic                          tensor_ack;
  logic                          frame_err;

  modport master (
    output s_valid, s_data, s_last, tensor_ack,
    input  s_ready, input_tensor, tensor_valid, frame_err
  );

  modport slave (
    input  s_valid, s_data, s_last, tensor_ack,
    output s_ready, input_tensor, tensor_valid, frame_err
  );
endinterface

// File: rtl/tensor_stream_packer.sv
// Assembles a raster-order element stream into one flat tensor; a fill buffer
// plus an output register let the next tensor stream in while one is held.
module tensor_stream_packer #(
  parameter int DATA_WIDTH  = 8,
  parameter int IN_CHANNELS = 1,
  parameter int IN_HEIGHT   = 4,
  parameter int IN_WIDTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  tensor_stream_packer_if.slave  bus
);

  localparam int IN_SIZE = IN_CHANNELS * IN_HEIGHT * IN_WIDTH;
  localparam int CNT_W   = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IN_SIZE - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [CNT_W-1:0]              r_idx;
  logic [CNT_W-1:0]              w_idx_nxt;
  logic [DATA_WIDTH-1:0]         r_fill_buf [IN_SIZE];
  logic [IN_SIZE*DATA_WIDTH-1:0] w_fill_flat;
  logic [IN_SIZE*DATA_WIDTH-1:0] r_tensor;
  logic                          r_tensor_valid;
  logic                          w_tensor_valid_nxt;
  logic                          r_frame_err;
  logic                          w_frame_err_nxt;
  logic                          w_beat;
  logic                          w_last_idx;
  logic                          w_slot_free;
  logic                          w_load;

  assign w_beat      = bus.s_valid && (r_state == FILL);
  assign w_last_idx  = (r_idx == LAST_IDX);
  assign w_slot_free = !r_tensor_valid || bus.tensor_ack;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt        = r_state;
    w_idx_nxt          = r_idx;
    w_frame_err_nxt    = 1'b0;
    w_load             = 1'b0;
    w_tensor_valid_nxt = r_tensor_valid;
    unique case (r_state)
      FILL: begin
        if (w_beat) begin
          if (w_last_idx && bus.s_last) begin
            w_idx_nxt   = '0;
            w_state_nxt = FULL;
          end else if (!w_last_idx && !bus.s_last) begin
            w_idx_nxt = r_idx + CNT_W'(1);
          end else begin
            // s_last disagrees with the element count: drop the partial tensor and resync.
            w_idx_nxt       = '0;
            w_frame_err_nxt = 1'b1;
          end
        end
      end
      FULL: begin
        if (w_slot_free) begin
          w_load      = 1'b1;
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase

    // A load in the same cycle as an ack keeps valid high: the new tensor replaces the old one.
    if (w_load) begin
      w_tensor_valid_nxt = 1'b1;
    end else if (r_tensor_valid && bus.tensor_ack) begin
      w_tensor_valid_nxt = 1'b0;
    end
  end

  always_comb begin
    w_fill_flat = '0;
    for (int i = 0; i < IN_SIZE; i++) begin
      w_fill_flat[i*DATA_WIDTH +: DATA_WIDTH] = r_fill_buf[i];
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= FILL;
      r_idx          <= '0;
      r_tensor       <= '0;
      r_tensor_valid <= 1'b0;
      r_frame_err    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_idx          <= w_idx_nxt;
      r_tensor_valid <= w_tensor_valid_nxt;
      r_frame_err    <= w_frame_err_nxt;
      if (w_load) begin
        r_tensor <= w_fill_flat;
      end
    end
  end

  // NOTE: the fill buffer is storage, not control; it is never read before being written, so it has no reset.
  always_ff @(posedge clk) begin
    if (w_beat) begin
      r_fill_buf[r_idx] <= bus.s_data;
    end
  end

  assign bus.s_ready      = (r_state == FILL);
  assign bus.input_tensor = r_tensor;
  assign bus.tensor_valid = r_tensor_valid;
  assign bus.frame_err    = r_frame_err;

endmodule

// File: tb/tb_tensor_stream_packer.sv
// Directed bench for tensor_stream_packer: framing, back-pressure, errors,
// signed pass-through, reset mid-stream and a randomized scoreboard run.
module tb_tensor_stream_packer;

  localparam int DW = 8;
  localparam int N  = 16;
  localparam int TW = N * DW;
  localparam int NF = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  tensor_stream_packer_if #(.DATA_WIDTH(DW), .IN_SIZE(N)) bus ();

  tensor_stream_packer #(
    .DATA_WIDTH (DW),
    .IN_CHANNELS(1),
    .IN_HEIGHT  (4),
    .IN_WIDTH   (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [TW-1:0] seq_tensor(input int start);
    logic [TW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[j*DW +: DW] = DW'(start + j);
    return v;
  endfunction

  // Holds one element until accepted; returns at the negedge after the beat.
  task automatic send(input logic [DW-1:0] d, input logic last);
    int waited;
    waited      = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    while (bus.s_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (bus.s_ready !== 1'b1) begin
      n_chk++; n_err++;
      $display("FAIL send_timeout: s_ready=%b required 1", bus.s_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_frame(input int start);
    for (int j = 0; j < N; j++) send(DW'(start + j), (j == N - 1));
  endtask

  task automatic wait_tvalid();
    int waited;
    waited = 0;
    while (bus.tensor_valid !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (bus.tensor_valid !== 1'b1) begin
      n_chk++; n_err++;
      $display("FAIL tvalid_timeout: tensor_valid=%b required 1", bus.tensor_valid);
    end
  endtask

  task automatic ack_pulse();
    bus.tensor_ack = 1'b1;
    @(negedge clk);
    bus.tensor_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready: got %b want 1", bus.s_ready); end
    n_chk++; if (bus.tensor_valid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b want 0", bus.tensor_valid); end
    n_chk++; if (bus.input_tensor !== '0) begin n_err++; $display("FAIL reset_tensor: got %h want 0", bus.input_tensor); end
    n_chk++; if (bus.frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b want 0", bus.frame_err); end
  endtask

  task automatic test_basic();
    bus.tensor_ack = 1'b1;
    send_frame(0);
    n_chk++; if (bus.tensor_valid !== 1'b0) begin n_err++; $display("FAIL basic_tvalid_early: got %b want 0", bus.tensor_valid); end
    n_chk++; if (bus.s_ready !== 1'b0) begin n_err++; $display("FAIL basic_full_ready: got %b want 0", bus.s_ready); end
    @(negedge clk);
    n_chk++; if (bus.tensor_valid !== 1'b1) begin n_err++; $display("FAIL basic_tvalid_rise: got %b want 1", bus.tensor_valid); end
    n_chk++; if (bus.input_tensor !== seq_tensor(0)) begin n_err++; $display("FAIL basic_data: got %h want %h", bus.input_tensor, seq_tensor(0)); end
    n_chk++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready_back: got %b want 1", bus.s_ready); end
    @(negedge clk);
    n_chk++; if (bus.tensor_valid !== 1'b0) begin n_err++; $display("FAIL basic_tvalid_fall: got %b want 0", bus.tensor_valid); end
    bus.tensor_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.tensor_ack = 1'b0;
    send_frame(0);
    send_frame(100);
    n_chk++; if (bus.tensor_valid !== 1'b1) begin n_err++; $display("FAIL b2b_a_valid: got %b want 1", bus.tensor_valid); end
    n_chk++; if (bus.input_tensor !== seq_tensor(0)) begin n_err++; $display("FAIL b2b_a_held: got %h want %h", bus.input_tensor, seq_tensor(0)); end
    n_chk++; if (bus.s_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full_ready: got %b want 0", bus.s_ready); end
    repeat (3) @(negedge clk);
    n_chk++; if (bus.input_tensor !== seq_tensor(0)) begin n_err++; $display("FAIL b2b_a_stable: got %h want %h", bus.input_tensor, seq_tensor(0)); end
    n_chk++; if (bus.s_ready !== 1'b0) begin n_err++; $display("FAIL b2b_still_full: got %b want 0", bus.s_ready); end
    ack_pulse();
    n_chk++; if (bus.tensor_valid !== 1'b1) begin n_err++; $display("FAIL b2b_no_gap: got %b want 1", bus.tensor_valid); end
    n_chk++; if (bus.input_tensor !== seq_tensor(100)) begin n_err++; $display("FAIL b2b_b_data: got %h want %h", bus.input_tensor, seq_tensor(100)); end
    n_chk++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_back: got %b want 1", bus.s_ready); end
    ack_pulse();
    n_chk++; if (bus.tensor_valid !== 1'b0) begin n_err++; $display("FAIL b2b_b_taken: got %b want 0", bus.tensor_valid); end
  endtask

  task automatic test_frame_err();
    // Early s_last on beat 5.
    for (int j = 0; j < 6; j++) send(DW'(j), (j == 5));
    n_chk++; if (bus.frame_err !== 1'b1) begin n_err++; $display("FAIL err_early_pulse: got %b want 1", bus.frame_err); end
    @(negedge clk);
    n_chk++; if (bus.frame_err !== 1'b0) begin n_err++; $display("FAIL err_early_width: got %b want 0", bus.frame_err); end
    n_chk++; if (bus.tensor_valid !== 1'b0) begin n_err++; $display("FAIL err_early_tvalid: got %b want 0", bus.tensor_valid); end
    send_frame(20);
    wait_tvalid();
    n_chk++; if (bus.input_tensor !== seq_tensor(20)) begin n_err++; $display("FAIL err_early_recover: got %h want %h", bus.input_tensor, seq_tensor(20)); end
    ack_pulse();
    // Missing s_last on beat 15.
    for (int j = 0; j < N; j++) send(DW'(40 + j), 1'b0);
    n_chk++; if (bus.frame_err !== 1'b1) begin n_err++; $display("FAIL err_late_pulse: got %b want 1", bus.frame_err); end
    @(negedge clk);
    n_chk++; if (bus.frame_err !== 1'b0) begin n_err++; $display("FAIL err_late_width: got %b want 0", bus.frame_err); end
    repeat (2) @(negedge clk);
    n_chk++; if (bus.tensor_valid !== 1'b0) begin n_err++; $display("FAIL err_late_tvalid: got %b want 0", bus.tensor_valid); end
    send_frame(60);
    wait_tvalid();
    n_chk++; if (bus.input_tensor !== seq_tensor(60)) begin n_err++; $display("FAIL err_late_recover: got %h want %h", bus.input_tensor, seq_tensor(60)); end
    ack_pulse();
  endtask

  task automatic test_signed();
    logic [DW-1:0] pat [4];
    logic [TW-1:0] exp_t;
    logic [TW-1:0] got_t;
    pat[0] = 8'h80; pat[1] = 8'h7F; pat[2] = 8'hFF; pat[3] = 8'h00;
    exp_t = '0;
    for (int j = 0; j < N; j++) exp_t[j*DW +: DW] = pat[j % 4];
    for (int j = 0; j < N; j++) send(pat[j % 4], (j == N - 1));
    wait_tvalid();
    got_t = bus.input_tensor;
    n_chk++; if (got_t !== exp_t) begin n_err++; $display("FAIL signed_bus: got %h want %h", got_t, exp_t); end
    n_chk++; if (got_t[DW-1:0] !== 8'h80) begin n_err++; $display("FAIL signed_min: got %h want 80", got_t[DW-1:0]); end
    n_chk++; if (got_t[2*DW-1:DW] !== 8'h7F) begin n_err++; $display("FAIL signed_max: got %h want 7f", got_t[2*DW-1:DW]); end
    ack_pulse();
  endtask

  task automatic test_reset_midstream();
    for (int j = 0; j < 10; j++) send(DW'(90 + j), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++; if (bus.input_tensor !== '0) begin n_err++; $display("FAIL rst_part_tensor: got %h want 0", bus.input_tensor); end
    n_chk++; if (bus.tensor_valid !== 1'b0) begin n_err++; $display("FAIL rst_part_tvalid: got %b want 0", bus.tensor_valid); end
    n_chk++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL rst_part_ready: got %b want 1", bus.s_ready); end
    send_frame(0);
    wait_tvalid();
    n_chk++; if (bus.input_tensor !== seq_tensor(0)) begin n_err++; $display("FAIL rst_part_next: got %h want %h", bus.input_tensor, seq_tensor(0)); end
    // Tensor left unacked, then reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++; if (bus.input_tensor !== '0) begin n_err++; $display("FAIL rst_held_tensor: got %h want 0", bus.input_tensor); end
    n_chk++; if (bus.tensor_valid !== 1'b0) begin n_err++; $display("FAIL rst_held_tvalid: got %b want 0", bus.tensor_valid); end
    n_chk++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL rst_held_ready: got %b want 1", bus.s_ready); end
    send_frame(0);
    wait_tvalid();
    n_chk++; if (bus.input_tensor !== seq_tensor(0)) begin n_err++; $display("FAIL rst_held_next: got %h want %h", bus.input_tensor, seq_tensor(0)); end
    ack_pulse();
  endtask

  task automatic test_random();
    logic [TW-1:0] sb [$];
    fork
      begin : producer
        for (int f = 0; f < NF; f++) begin
          logic [DW-1:0] el [N];
          logic [TW-1:0] v;
          v = '0;
          for (int j = 0; j < N; j++) begin
            el[j] = DW'($urandom);
            v[j*DW +: DW] = el[j];
          end
          sb.push_back(v);
          for (int j = 0; j < N; j++) begin
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            send(el[j], (j == N - 1));
          end
        end
      end
      begin : consumer
        int got;
        int cyc;
        logic [TW-1:0] exp_t;
        got = 0;
        cyc = 0;
        while (got < NF && cyc < 3000) begin
          @(negedge clk);
          cyc++;
          bus.tensor_ack = ($urandom_range(0, 1) == 1);
          if (bus.tensor_valid === 1'b1 && bus.tensor_ack === 1'b1) begin
            n_chk++;
            if (sb.size() == 0) begin
              n_err++;
              $display("FAIL rand_extra_tensor: got %h want none", bus.input_tensor);
            end else begin
              exp_t = sb.pop_front();
              if (bus.input_tensor !== exp_t) begin
                n_err++;
                $display("FAIL rand_tensor_%0d: got %h want %h", got, bus.input_tensor, exp_t);
              end
            end
            got++;
          end
        end
        @(negedge clk);
        bus.tensor_ack = 1'b0;
        n_chk++;
        if (got < NF) begin
          n_err++;
          $display("FAIL rand_timeout: got %0d tensors want %0d", got, NF);
        end else if (bus.tensor_valid !== 1'b0) begin
          n_err++;
          $display("FAIL rand_drain: tensor_valid=%b want 0", bus.tensor_valid);
        end
      end
    join
  endtask

  initial begin
    bus.s_valid    = 1'b0;
    bus.s_data     = '0;
    bus.s_last     = 1'b0;
    bus.tensor_ack = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_frame_err();
    test_signed();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
